// File: rtl/writeback_sequencer.sv
// Multicycle register-file writeback controller: stack-pointer init after reset,
// then one request at a time, with an optional memory read for load sources.
module writeback_sequencer #(
   parameter int MEM_LAT = 2,
   parameter int SP_REG  = 29
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wb_req,
   input  logic [3:0] wb_src,
   input  logic [4:0] wb_rd,
   output logic       mem_rd,
   output logic [3:0] mem_to_reg,
   output logic [4:0] reg_dst_addr,
   output logic       reg_write,
   output logic       wb_busy,
   output logic       wb_done
);

   typedef enum logic [2:0] {
      S_INIT_SP,
      S_IDLE,
      S_MEM_RD,
      S_MEM_WAIT,
      S_WRITE
   } state_t;

   localparam logic [3:0] SP_SEL  = 4'b0111;
   localparam logic [4:0] SP_ADDR = 5'(SP_REG);
   localparam logic [3:0] LAT_M1  = 4'(MEM_LAT - 1);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_next;
   logic [3:0] r_src;
   logic [4:0] r_rd;
   logic [3:0] r_sel;
   logic [4:0] r_addr;
   logic       w_is_load;

   assign w_is_load = (wb_src == 4'b0001) || (wb_src == 4'b0010) || (wb_src == 4'b0011);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_INIT_SP;
         r_cnt   <= 4'd0;
         r_sel   <= SP_SEL;
         r_addr  <= SP_ADDR;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         // Selector and address keep the last written values between writebacks
         if (r_state == S_WRITE) begin
            r_sel  <= r_src;
            r_addr <= r_rd;
         end
      end
   end

   // Request operands are captured only on acceptance; later input changes are ignored
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && wb_req) begin
         r_src <= wb_src;
         r_rd  <= wb_rd;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_cnt_next   = r_cnt;
      mem_rd       = 1'b0;
      reg_write    = 1'b0;
      wb_done      = 1'b0;
      wb_busy      = 1'b1;
      mem_to_reg   = r_sel;
      reg_dst_addr = r_addr;
      case (r_state)
         S_INIT_SP: begin
            reg_write    = 1'b1;
            mem_to_reg   = SP_SEL;
            reg_dst_addr = SP_ADDR;
            w_next       = S_IDLE;
         end
         S_IDLE: begin
            wb_busy = 1'b0;
            if (wb_req) begin
               w_next = w_is_load ? S_MEM_RD : S_WRITE;
            end
         end
         S_MEM_RD: begin
            mem_rd     = 1'b1;
            w_cnt_next = LAT_M1;
            w_next     = (MEM_LAT == 1) ? S_WRITE : S_MEM_WAIT;
         end
         S_MEM_WAIT: begin
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_next = S_WRITE;
            end
         end
         S_WRITE: begin
            mem_to_reg   = r_src;
            reg_dst_addr = r_rd;
            wb_done      = 1'b1;
            reg_write    = (r_rd != 5'd0);
            w_next       = S_IDLE;
         end
         default: begin
            w_next = S_INIT_SP;
         end
      endcase
      // A reset cycle suppresses every strobe so an interrupted writeback never lands
      if (reset) begin
         mem_rd       = 1'b0;
         reg_write    = 1'b0;
         wb_done      = 1'b0;
         wb_busy      = 1'b1;
         mem_to_reg   = SP_SEL;
         reg_dst_addr = SP_ADDR;
      end
   end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed bench for writeback_sequencer: a countdown-based reference model checked
// every cycle, plus hand-computed literal expectations for the scenarios of interest.
module tb_writeback_sequencer;

   localparam int MEM_LAT = 2;
   localparam int SP_REG  = 29;

   logic       clk = 1'b0;
   logic       reset;
   logic       wb_req;
   logic [3:0] wb_src;
   logic [4:0] wb_rd;
   logic       mem_rd;
   logic [3:0] mem_to_reg;
   logic [4:0] reg_dst_addr;
   logic       reg_write;
   logic       wb_busy;
   logic       wb_done;

   int n_tests = 0;
   int n_fail  = 0;

   writeback_sequencer #(.MEM_LAT(MEM_LAT), .SP_REG(SP_REG)) dut (
      .clk(clk), .reset(reset), .wb_req(wb_req), .wb_src(wb_src), .wb_rd(wb_rd),
      .mem_rd(mem_rd), .mem_to_reg(mem_to_reg), .reg_dst_addr(reg_dst_addr),
      .reg_write(reg_write), .wb_busy(wb_busy), .wb_done(wb_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a pending writeback is just "cycles left until the write"
   bit         m_valid = 0;
   bit         m_init;
   bit         m_active;
   bit         m_first;
   int         m_left;
   logic [3:0] m_src, m_sel;
   logic [4:0] m_rd, m_addr;

   function automatic bit is_load(input logic [3:0] s);
      return (s == 4'd1) || (s == 4'd2) || (s == 4'd3);
   endfunction

   always @(posedge clk) begin
      m_valid = 1;
      if (reset) begin
         m_init = 1; m_active = 0; m_first = 0; m_left = 0;
         m_sel = 4'b0111; m_addr = 5'(SP_REG);
      end else if (m_init) begin
         m_init = 0;
      end else if (m_active) begin
         if (m_left == 0) begin
            m_active = 0; m_sel = m_src; m_addr = m_rd;
         end else begin
            m_left--; m_first = 0;
         end
      end else if (wb_req) begin
         m_active = 1; m_src = wb_src; m_rd = wb_rd;
         m_first  = is_load(wb_src);
         m_left   = is_load(wb_src) ? MEM_LAT : 0;
      end
   end

   always @(negedge clk) begin
      logic       e_rd, e_rw, e_busy, e_done;
      logic [3:0] e_sel;
      logic [4:0] e_addr;
      if (m_valid) begin
         e_rd = 0; e_rw = 0; e_busy = 1; e_done = 0; e_sel = m_sel; e_addr = m_addr;
         if (reset) begin
            e_sel = 4'b0111; e_addr = 5'(SP_REG);
         end else if (m_init) begin
            e_rw = 1; e_sel = 4'b0111; e_addr = 5'(SP_REG);
         end else if (m_active) begin
            e_rd = m_first;
            if (m_left == 0) begin
               e_done = 1; e_rw = (m_rd != 0); e_sel = m_src; e_addr = m_rd;
            end
         end else begin
            e_busy = 0;
         end
         check("model_mem_rd", 32'(mem_rd), 32'(e_rd));
         check("model_reg_write", 32'(reg_write), 32'(e_rw));
         check("model_busy", 32'(wb_busy), 32'(e_busy));
         check("model_done", 32'(wb_done), 32'(e_done));
         check("model_sel", 32'(mem_to_reg), 32'(e_sel));
         check("model_addr", 32'(reg_dst_addr), 32'(e_addr));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic req(input logic [3:0] s, input logic [4:0] r);
      wb_req = 1; wb_src = s; wb_rd = r;
      step();
      wb_req = 0;
   endtask

   initial begin
      reset = 1; wb_req = 0; wb_src = 4'd0; wb_rd = 5'd0;

      // Reset held three cycles, then SP init, then IDLE
      repeat (3) step();
      check("rst_rw", 32'(reg_write), 32'd0);
      check("rst_busy", 32'(wb_busy), 32'd1);
      check("rst_sel", 32'(mem_to_reg), 32'h7);
      check("rst_addr", 32'(reg_dst_addr), 32'd29);
      reset = 0; #1;
      check("sp_rw", 32'(reg_write), 32'd1);
      check("sp_sel", 32'(mem_to_reg), 32'h7);
      check("sp_addr", 32'(reg_dst_addr), 32'd29);
      check("sp_done", 32'(wb_done), 32'd0);
      step();
      check("idle_busy", 32'(wb_busy), 32'd0);
      check("idle_rw", 32'(reg_write), 32'd0);

      // ALU writeback to $8
      req(4'd0, 5'd8);
      check("alu_rw", 32'(reg_write), 32'd1);
      check("alu_sel", 32'(mem_to_reg), 32'd0);
      check("alu_addr", 32'(reg_dst_addr), 32'd8);
      check("alu_done", 32'(wb_done), 32'd1);
      check("alu_memrd", 32'(mem_rd), 32'd0);
      step();

      // Halfword load to $9; inputs scrambled after acceptance
      req(4'd2, 5'd9);
      wb_src = 4'hF; wb_rd = 5'd1;
      check("ld_memrd", 32'(mem_rd), 32'd1);
      check("ld_busy1", 32'(wb_busy), 32'd1);
      check("ld_hold_sel", 32'(mem_to_reg), 32'd0);
      check("ld_hold_addr", 32'(reg_dst_addr), 32'd8);
      step();
      check("ld_wait_memrd", 32'(mem_rd), 32'd0);
      check("ld_wait_rw", 32'(reg_write), 32'd0);
      check("ld_busy2", 32'(wb_busy), 32'd1);
      step();
      check("ld_rw", 32'(reg_write), 32'd1);
      check("ld_sel", 32'(mem_to_reg), 32'd2);
      check("ld_addr", 32'(reg_dst_addr), 32'd9);
      check("ld_busy3", 32'(wb_busy), 32'd1);
      step();
      check("ld_idle", 32'(wb_busy), 32'd0);

      // HI to $0: done pulses, no write
      req(4'd4, 5'd0);
      check("r0_done", 32'(wb_done), 32'd1);
      check("r0_rw", 32'(reg_write), 32'd0);
      step();

      // Request pulsed during a load wait is dropped
      req(4'd1, 5'd3);
      step();
      wb_req = 1; wb_src = 4'd0; wb_rd = 5'd5;
      step();
      wb_req = 0;
      check("ign_sel", 32'(mem_to_reg), 32'd1);
      check("ign_addr", 32'(reg_dst_addr), 32'd3);
      step();
      check("ign_idle_rw", 32'(reg_write), 32'd0);
      step();
      check("ign_none_rw", 32'(reg_write), 32'd0);

      // Reset in MEM_WAIT aborts the load and repeats SP init
      req(4'd3, 5'd7);
      step();
      reset = 1; #1;
      check("abort_rw", 32'(reg_write), 32'd0);
      step();
      check("abort_rst_rw", 32'(reg_write), 32'd0);
      reset = 0; #1;
      check("abort_sp_rw", 32'(reg_write), 32'd1);
      check("abort_sp_addr", 32'(reg_dst_addr), 32'd29);
      step();
      check("abort_idle", 32'(wb_busy), 32'd0);

      // Non-load codes, a held request across WRITE->IDLE, and reset during WRITE
      for (int i = 0; i < 4; i++) begin
         logic [3:0] codes [4];
         codes = '{4'd5, 4'd7, 4'd8, 4'd12};
         req(codes[i], 5'(10 + i));
         check("nl_sel", 32'(mem_to_reg), 32'(codes[i]));
         step();
      end
      wb_req = 1; wb_src = 4'd6; wb_rd = 5'd17;
      repeat (5) step();
      wb_req = 0;
      step();
      req(4'd9, 5'd20);
      reset = 1; #1;
      check("wr_rst_rw", 32'(reg_write), 32'd0);
      step();
      reset = 0;
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
